// File: rtl/bpu_pkg.sv
// Shared types and CNT_W-generic saturating counter helpers for the branch predictor.
package bpu_pkg;

    // Widest prediction counter the helpers handle; callers zero-extend and truncate.
    localparam int unsigned CNT_MAX_W = 16;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_DIR,
        RD_TGT,
        RD_ALIAS
    } rd_reason_t;

    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [CNT_MAX_W-1:0] top;
        top = (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
        return (v >= top) ? top : v + CNT_MAX_W'(1);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bpu_perf_cnt.sv
// Saturating 32-bit event counter with asynchronous active-high clear.
module bpu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters and mispredict/redirect logic.
// Optional resolved-branch and mispredict counters are built when BPU_STATS_EN is defined.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_vld,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_is_br,
    input  logic        i_upd_is_jmp,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_stat_br,
    output logic [31:0] o_stat_mis
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             is_ctrl;
    logic             unused_pc_bits;
    rd_reason_t       reason;

    logic             wr_en;
    logic             wr_valid;
    logic [31:0]      wr_tgt;
    logic [CNT_W-1:0] wr_cnt;

    assign if_idx  = i_if_pc[IDX_W+1:2];
    assign if_tag  = i_if_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign is_ctrl = i_upd_is_br || i_upd_is_jmp;

    assign unused_pc_bits = ^i_if_pc;

    // Asynchronous read of the pre-update table; no bypass from a same-cycle write.
    always_comb begin
        o_pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        o_pred_taken  = o_pred_hit && cnt_q[if_idx][CNT_W-1];
        o_pred_target = o_pred_hit ? tgt_q[if_idx] : '0;
    end

    always_comb begin
        reason = RD_NONE;
        if (i_upd_vld) begin
            if (is_ctrl) begin
                if (i_upd_pred_taken != i_upd_taken) begin
                    reason = RD_DIR;
                end else if (i_upd_taken && (i_upd_pred_target != i_upd_target)) begin
                    reason = RD_TGT;
                end
            end else if (i_upd_pred_taken) begin
                reason = RD_ALIAS;
            end
        end
    end

    assign o_mispredict  = (reason != RD_NONE);
    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_tgt   = tgt_q[upd_idx];
        wr_cnt   = cnt_q[upd_idx];
        if (i_upd_vld) begin
            if (i_upd_is_jmp) begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_tgt   = i_upd_target;
                wr_cnt   = CNT_MAX;
            end else if (i_upd_is_br) begin
                if (upd_hit) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_cnt   = i_upd_taken
                             ? CNT_W'(sat_inc(CNT_MAX_W'(cnt_q[upd_idx]), CNT_W))
                             : CNT_W'(sat_dec(CNT_MAX_W'(cnt_q[upd_idx])));
                    if (i_upd_taken) begin
                        wr_tgt = i_upd_target;
                    end
                end else if (i_upd_taken) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_tgt   = i_upd_target;
                    wr_cnt   = CNT_WEAK;
                end
            end else if ((reason == RD_ALIAS) && upd_hit) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= wr_valid;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= wr_tgt;
            cnt_q[upd_idx]   <= wr_cnt;
        end
    end

`ifdef BPU_STATS_EN
    bpu_perf_cnt u_stat_br (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (i_upd_vld && is_ctrl),
        .count (o_stat_br)
    );

    bpu_perf_cnt u_stat_mis (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (o_mispredict),
        .count (o_stat_mis)
    );
`else
    assign o_stat_br  = '0;
    assign o_stat_mis = '0;
`endif

endmodule
